// File: rtl/pwm_ctrl_pkg.sv
// Shared types and step arithmetic for the slew-limited PWM duty controller.
package pwm_ctrl_pkg;

    localparam int DUTY_W           = 11;
    localparam int STEP_DEF         = 16;
    localparam int DUTY_MAX_DEF     = 1945;
    localparam int WDOG_PERIODS_DEF = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        HOLD  = 3'd2,
        BRAKE = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Move cur toward tgt by at most step; unsigned, never overshoots or wraps.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt,
                                                      input logic [DUTY_W-1:0] step);
        logic [DUTY_W-1:0] diff;
        if (tgt >= cur) begin
            diff = tgt - cur;
            return (diff <= step) ? tgt : cur + step;
        end
        diff = cur - tgt;
        return (diff <= step) ? tgt : cur - step;
    endfunction

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] req,
                                                   input logic [DUTY_W-1:0] cap);
        return (req > cap) ? cap : req;
    endfunction

endpackage

// File: rtl/pwm_duty_ctrl_wdog.sv
// Watchdog counting PWM periods without a fresh target; pulses expire on the
// synch that completes WDOG_PERIODS periods.
module pwm_wdog #(
    parameter int WDOG_PERIODS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic synch,
    input  logic clr,
    output logic expire
);

    localparam int                CNT_W = $clog2(WDOG_PERIODS + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WDOG_PERIODS - 1);

    logic [CNT_W-1:0] cnt;

    // A clear in the same cycle as the final synch suppresses the expiry.
    assign expire = count_en & synch & ~clr & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || !count_en) begin
            cnt <= '0;
        end else if (synch) begin
            cnt <= expire ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Slew-limited duty controller: steps duty toward an accepted target once per
// PWM period, with brake / enable / watchdog-fault overrides forcing zero.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int STEP         = STEP_DEF,
    parameter int DUTY_MAX     = DUTY_MAX_DEF,
    parameter int WDOG_PERIODS = WDOG_PERIODS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              brake,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_vld,
    output logic              tgt_rdy,
    input  logic              PWM_synch,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              at_tgt,
    output logic              fault,
    output logic [2:0]        state_dbg
);

    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);

    state_t            state, state_nxt;
    logic [DUTY_W-1:0] tgt, tgt_acc, tgt_nxt, duty_nxt, ramp_duty;
    logic              fault_nxt, accept, active, expire;

    // Handshake: a target is taken on any cycle where tgt_vld and tgt_rdy are
    // both high; tgt_rdy is combinational and never depends on tgt_vld.
    assign tgt_rdy   = ~rst & ~brake & (state == IDLE || state == RAMP || state == HOLD);
    assign accept    = tgt_vld & tgt_rdy;
    assign tgt_acc   = accept ? sat_duty(tgt_duty, MAX_V) : tgt;
    assign active    = (state == RAMP) || (state == HOLD);
    // The step uses the registered target, so a same-cycle accept lands next period.
    assign ramp_duty = (state == RAMP && PWM_synch) ? step_toward(duty, tgt, STEP_V) : duty;
    assign state_dbg = state;

    pwm_wdog #(.WDOG_PERIODS(WDOG_PERIODS)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (active),
        .synch    (PWM_synch),
        .clr      (accept | ~active),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            duty  <= '0;
            tgt   <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            tgt   <= tgt_nxt;
            fault <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == FAULT) begin
            if (clr_fault && !en) state_nxt = IDLE;
        end else if (expire) begin
            state_nxt = FAULT;
        end else if (brake) begin
            state_nxt = BRAKE;
        end else if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, BRAKE: state_nxt = (tgt_acc != '0) ? RAMP : HOLD;
                RAMP:        if (ramp_duty == tgt_acc) state_nxt = HOLD;
                HOLD:        if (accept && tgt_acc != duty) state_nxt = RAMP;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // Zero-forcing states clear duty immediately; BRAKE and FAULT also drop the target.
    always_comb begin
        duty_nxt  = ramp_duty;
        tgt_nxt   = tgt_acc;
        fault_nxt = 1'b0;
        at_tgt    = (state == HOLD);
        case (state_nxt)
            IDLE: duty_nxt = '0;
            BRAKE: begin
                duty_nxt = '0;
                tgt_nxt  = '0;
            end
            FAULT: begin
                duty_nxt  = '0;
                tgt_nxt   = '0;
                fault_nxt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scenario bench for pwm_duty_ctrl: ramp sequences predicted by closed-form
// slew arithmetic, plus override, watchdog and reset scenarios.
module tb_pwm_duty_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int STEP = 16;
    localparam int DMAX = 1945;
    localparam int WDOG = 64;

    logic        clk = 1'b0;
    logic        rst, en, brake, tgt_vld, tgt_rdy, PWM_synch, clr_fault, at_tgt, fault;
    logic [10:0] tgt_duty, duty;
    logic [2:0]  state_dbg;

    int          checks = 0;
    int          failures = 0;
    int          model_duty = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_duty_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .brake     (brake),
        .tgt_duty  (tgt_duty),
        .tgt_vld   (tgt_vld),
        .tgt_rdy   (tgt_rdy),
        .PWM_synch (PWM_synch),
        .clr_fault (clr_fault),
        .duty      (duty),
        .at_tgt    (at_tgt),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete (checks=%0d)", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_synch();
        PWM_synch = 1'b1;
        tick();
        PWM_synch = 1'b0;
    endtask

    task automatic do_accept(input int v, input bit with_synch, input string name);
        tgt_duty  = 11'(v);
        tgt_vld   = 1'b1;
        PWM_synch = with_synch;
        #1;
        checks++;
        if (tgt_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s_rdy: tgt_rdy=%b expected 1", name, tgt_rdy);
        end
        @(posedge clk);
        #1;
        tgt_vld   = 1'b0;
        PWM_synch = 1'b0;
    endtask

    // Expected ramp: k-th period lands at start +/- k*STEP, clipped at the target.
    task automatic run_ramp(input int req, input string name);
        int eff, n, v, prev, gap;
        eff = (req > DMAX) ? DMAX : req;
        n = ((eff > model_duty) ? eff - model_duty : model_duty - eff);
        n = (n + STEP - 1) / STEP;
        exp_q.delete();
        for (int k = 1; k <= n; k++) begin
            if (eff > model_duty) v = (model_duty + k * STEP < eff) ? model_duty + k * STEP : eff;
            else                  v = (model_duty - k * STEP > eff) ? model_duty - k * STEP : eff;
            exp_q.push_back(11'(v));
        end
        do_accept(req, 1'b0, name);
        prev = model_duty;
        checks++;
        if (at_tgt !== ((n == 0) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL %s_start_at_tgt: at_tgt=%b expected %b", name, at_tgt, (n == 0));
        end
        while (exp_q.size() > 0) begin
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (duty !== 11'(prev)) begin
                    failures++;
                    $display("FAIL %s_no_synch_hold: duty=%0d expected %0d", name, duty, prev);
                end
            end
            do_synch();
            v = int'(exp_q.pop_front());
            checks++;
            if (duty !== 11'(v)) begin
                failures++;
                $display("FAIL %s_step: duty=%0d expected %0d", name, duty, v);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (at_tgt !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_mid_at_tgt: at_tgt=%b expected 0 at duty %0d", name, at_tgt, v);
                end
            end
            prev = v;
        end
        if (n == 0) begin
            do_synch();
            checks++;
            if (duty !== 11'(prev)) begin
                failures++;
                $display("FAIL %s_hold_duty: duty=%0d expected %0d", name, duty, prev);
            end
        end
        checks++;
        if (at_tgt !== 1'b1) begin
            failures++;
            $display("FAIL %s_end_at_tgt: at_tgt=%b expected 1", name, at_tgt);
        end
        model_duty = eff;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; brake = 1'b0; tgt_vld = 1'b0; tgt_duty = '0;
        PWM_synch = 1'b0; clr_fault = 1'b0;
        tick();
        tick();
        checks += 4;
        if (duty !== 11'd0)     begin failures++; $display("FAIL reset_duty: duty=%0d expected 0", duty); end
        if (fault !== 1'b0)     begin failures++; $display("FAIL reset_fault: fault=%b expected 0", fault); end
        if (at_tgt !== 1'b0)    begin failures++; $display("FAIL reset_at_tgt: at_tgt=%b expected 0", at_tgt); end
        if (tgt_rdy !== 1'b0)   begin failures++; $display("FAIL reset_rdy: tgt_rdy=%b expected 0", tgt_rdy); end
        checks++;
        if (state_dbg !== 3'(IDLE)) begin failures++; $display("FAIL reset_state: state=%0d expected %0d", state_dbg, IDLE); end
        rst = 1'b0;
        model_duty = 0;
    endtask

    task automatic test_ramp_up();
        en = 1'b1;
        tick();
        checks++;
        if (at_tgt !== 1'b1) begin failures++; $display("FAIL enable_hold_zero: at_tgt=%b expected 1", at_tgt); end
        run_ramp(100, "ramp_up_100");
    endtask

    task automatic test_ramp_down_and_clamp();
        run_ramp(40, "ramp_down_40");
        run_ramp(1000, "ramp_up_1000");
        run_ramp(1900, "ramp_up_1900");
        run_ramp(2047, "clamp_2047");
    endtask

    task automatic test_random_ramps();
        int lo, hi;
        for (int i = 0; i < 6; i++) begin
            lo = (model_duty > 900) ? model_duty - 900 : 0;
            hi = (model_duty + 900 < 2047) ? model_duty + 900 : 2047;
            run_ramp(int'($urandom_range(hi, lo)), "random_ramp");
        end
    endtask

    task automatic test_brake();
        en = 1'b0;
        tick();
        checks++;
        if (duty !== 11'd0) begin failures++; $display("FAIL disable_zero: duty=%0d expected 0", duty); end
        do_accept(200, 1'b0, "idle_accept");
        en = 1'b1;
        tick();
        model_duty = 0;
        for (int k = 1; k <= 3; k++) begin
            do_synch();
            checks++;
            if (duty !== 11'(k * STEP)) begin failures++; $display("FAIL brake_pre_ramp: duty=%0d expected %0d", duty, k * STEP); end
        end
        brake = 1'b1;
        #1;
        checks++;
        if (tgt_rdy !== 1'b0) begin failures++; $display("FAIL brake_rdy_comb: tgt_rdy=%b expected 0", tgt_rdy); end
        tick();
        checks += 2;
        if (duty !== 11'd0)   begin failures++; $display("FAIL brake_duty: duty=%0d expected 0", duty); end
        if (tgt_rdy !== 1'b0) begin failures++; $display("FAIL brake_rdy: tgt_rdy=%b expected 0", tgt_rdy); end
        brake = 1'b0;
        tick();
        checks++;
        if (at_tgt !== 1'b1) begin failures++; $display("FAIL brake_release_hold: at_tgt=%b expected 1", at_tgt); end
        do_synch();
        do_synch();
        checks++;
        if (duty !== 11'd0) begin failures++; $display("FAIL brake_tgt_cleared: duty=%0d expected 0", duty); end
    endtask

    task automatic test_enable();
        model_duty = 0;
        do_accept(80, 1'b0, "en_accept");
        do_synch();
        checks++;
        if (duty !== 11'd16) begin failures++; $display("FAIL en_first_step: duty=%0d expected 16", duty); end
        en = 1'b0;
        tick();
        checks += 2;
        if (duty !== 11'd0) begin failures++; $display("FAIL en_low_duty: duty=%0d expected 0", duty); end
        if (state_dbg !== 3'(IDLE)) begin failures++; $display("FAIL en_low_state: state=%0d expected %0d", state_dbg, IDLE); end
        en = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            do_synch();
            checks++;
            if (duty !== 11'(k * STEP)) begin failures++; $display("FAIL en_retained_tgt: duty=%0d expected %0d", duty, k * STEP); end
        end
        checks++;
        if (at_tgt !== 1'b1) begin failures++; $display("FAIL en_reach_80: at_tgt=%b expected 1", at_tgt); end
        model_duty = 80;
    endtask

    task automatic test_watchdog();
        do_accept(model_duty, 1'b0, "wd_refresh");
        for (int i = 0; i < WDOG - 1; i++) do_synch();
        checks += 2;
        if (fault !== 1'b0) begin failures++; $display("FAIL wd_early: fault=%b expected 0", fault); end
        if (duty !== 11'(model_duty)) begin failures++; $display("FAIL wd_early_duty: duty=%0d expected %0d", duty, model_duty); end
        do_synch();
        checks += 3;
        if (fault !== 1'b1)   begin failures++; $display("FAIL wd_expire: fault=%b expected 1", fault); end
        if (duty !== 11'd0)   begin failures++; $display("FAIL wd_duty: duty=%0d expected 0", duty); end
        if (tgt_rdy !== 1'b0) begin failures++; $display("FAIL wd_rdy: tgt_rdy=%b expected 0", tgt_rdy); end
        clr_fault = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL wd_clr_with_en: fault=%b expected 1", fault); end
        en = 1'b0;
        tick();
        clr_fault = 1'b0;
        checks += 2;
        if (fault !== 1'b0) begin failures++; $display("FAIL wd_clr: fault=%b expected 0", fault); end
        if (state_dbg !== 3'(IDLE)) begin failures++; $display("FAIL wd_clr_state: state=%0d expected %0d", state_dbg, IDLE); end
        en = 1'b1;
        tick();
        model_duty = 0;
        // Accept arriving together with the expiring synch keeps the controller out of FAULT.
        do_accept(0, 1'b0, "wd_race_prep");
        for (int i = 0; i < WDOG - 1; i++) do_synch();
        do_accept(0, 1'b1, "wd_race");
        checks++;
        if (fault !== 1'b0) begin failures++; $display("FAIL wd_accept_wins: fault=%b expected 0", fault); end
        for (int i = 0; i < WDOG - 1; i++) do_synch();
        checks++;
        if (fault !== 1'b0) begin failures++; $display("FAIL wd_restart_early: fault=%b expected 0", fault); end
        do_synch();
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL wd_restart_expire: fault=%b expected 1", fault); end
        clr_fault = 1'b1;
        en = 1'b0;
        tick();
        clr_fault = 1'b0;
        en = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        do_accept(100, 1'b0, "b2b_first");
        do_synch();
        checks++;
        if (duty !== 11'd16) begin failures++; $display("FAIL b2b_step1: duty=%0d expected 16", duty); end
        do_accept(20, 1'b1, "b2b_with_synch");
        checks += 2;
        if (duty !== 11'd32) begin failures++; $display("FAIL b2b_old_tgt: duty=%0d expected 32", duty); end
        if (at_tgt !== 1'b0) begin failures++; $display("FAIL b2b_mid: at_tgt=%b expected 0", at_tgt); end
        do_synch();
        checks += 2;
        if (duty !== 11'd20) begin failures++; $display("FAIL b2b_new_tgt: duty=%0d expected 20", duty); end
        if (at_tgt !== 1'b1) begin failures++; $display("FAIL b2b_hold: at_tgt=%b expected 1", at_tgt); end
        do_accept(500, 1'b0, "rst_ramp");
        do_synch();
        do_synch();
        checks++;
        if (duty !== 11'd52) begin failures++; $display("FAIL rst_pre: duty=%0d expected 52", duty); end
        rst = 1'b1;
        tick();
        checks += 5;
        if (duty !== 11'd0)   begin failures++; $display("FAIL rst_mid_duty: duty=%0d expected 0", duty); end
        if (state_dbg !== 3'(IDLE)) begin failures++; $display("FAIL rst_mid_state: state=%0d expected %0d", state_dbg, IDLE); end
        if (at_tgt !== 1'b0)  begin failures++; $display("FAIL rst_mid_at_tgt: at_tgt=%b expected 0", at_tgt); end
        if (fault !== 1'b0)   begin failures++; $display("FAIL rst_mid_fault: fault=%b expected 0", fault); end
        if (tgt_rdy !== 1'b0) begin failures++; $display("FAIL rst_mid_rdy: tgt_rdy=%b expected 0", tgt_rdy); end
        rst = 1'b0;
        tick();
        checks++;
        if (state_dbg !== 3'(HOLD)) begin failures++; $display("FAIL rst_tgt_discarded: state=%0d expected %0d", state_dbg, HOLD); end
        do_synch();
        checks++;
        if (duty !== 11'd0) begin failures++; $display("FAIL rst_post_synch: duty=%0d expected 0", duty); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down_and_clamp();
        test_random_ramps();
        test_brake();
        test_enable();
        test_watchdog();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
